thread_issue_scheduler: RTL

- Selects which of four hardware threads owns the fetch/issue slot each cycle.
- Drives the select and flush inputs of the per-thread instruction-bundle demux that sits between fetch and the four thread pipelines.
- Scheduling policy: round-robin with a per-thread issue quantum, a context-switch bubble, and per-thread block/flush gating.
- Also keeps saturating per-thread issue counters for performance monitoring.

---
 rtl/thread_issue_scheduler_if.sv | 25 ++
 rtl/thread_issue_scheduler.sv | 129 ++++++++++++
 2 files changed

// File: rtl/thread_issue_scheduler_if.sv
// Handshake bundle between the fetch-slot scheduler and its environment:
// thread enables/blocks/flush in, demux select/valid/flush and perf counters out.
interface thread_issue_scheduler_if #(
    parameter int unsigned COUNT_WIDTH = 16
);
    logic [3:0]               i_Enable;
    logic [3:0]               i_Blocked;
    logic                     i_Stall;
    logic                     i_Flush_Valid;
    logic [1:0]               i_Flush_Thread;
    logic [1:0]               o_thread;
    logic                     o_Valid;
    logic                     o_Demux_Flush;
    logic [4*COUNT_WIDTH-1:0] o_Issue_Count;

    modport master (
        output i_Enable, i_Blocked, i_Stall, i_Flush_Valid, i_Flush_Thread,
        input  o_thread, o_Valid, o_Demux_Flush, o_Issue_Count
    );

    modport slave (
        input  i_Enable, i_Blocked, i_Stall, i_Flush_Valid, i_Flush_Thread,
        output o_thread, o_Valid, o_Demux_Flush, o_Issue_Count
    );
endinterface

// File: rtl/thread_issue_scheduler.sv
// Four-thread fetch/issue slot scheduler: round-robin with issue quantum,
// context-switch bubbles, block/flush gating and saturating issue counters.
module thread_issue_scheduler #(
    parameter int unsigned QUANTUM        = 4,
    parameter int unsigned SWITCH_PENALTY = 1,
    parameter int unsigned COUNT_WIDTH    = 16
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset,
    thread_issue_scheduler_if.slave   bus
);
    localparam int unsigned NUM_THREADS = 4;
    localparam int unsigned QCNT_W      = 8;
    localparam int unsigned PCNT_W      = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_SWITCH = 2'd2
    } state_t;

    state_t                   state;
    logic [1:0]               cur_thread;
    logic                     valid_q;
    logic [1:0]               rr_ptr;
    logic [QCNT_W-1:0]        qcnt;
    logic [PCNT_W-1:0]        pcnt;
    logic [NUM_THREADS-1:0]   flush_hold;
    logic [COUNT_WIDTH-1:0]   cnt [NUM_THREADS];

    logic [NUM_THREADS-1:0]   elig;
    logic [2:0]               pick_rr;
    logic [2:0]               pick_nx;

    // Returns {found, thread}: first eligible thread scanning cyclically from ptr.
    function automatic logic [2:0] pick_from(input logic [1:0] ptr, input logic [3:0] el);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (el[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + COUNT_WIDTH'(1);
    endfunction

    always_comb begin
        elig    = bus.i_Enable & ~bus.i_Blocked & ~flush_hold;
        pick_rr = pick_from(rr_ptr, elig);
        pick_nx = pick_from(cur_thread + 2'd1, elig);
    end

    // Flush requests are captured even under stall and released on the next live edge.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            flush_hold <= '0;
        end else begin
            for (int t = 0; t < int'(NUM_THREADS); t++) begin
                if (bus.i_Flush_Valid && (bus.i_Flush_Thread == 2'(t)))
                    flush_hold[t] <= 1'b1;
                else if (!bus.i_Stall)
                    flush_hold[t] <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state      <= S_IDLE;
            cur_thread <= 2'd0;
            valid_q    <= 1'b0;
            rr_ptr     <= 2'd0;
            qcnt       <= '0;
            pcnt       <= '0;
            for (int t = 0; t < int'(NUM_THREADS); t++) cnt[t] <= '0;
        end else if (!bus.i_Stall) begin
            if (state == S_RUN) begin
                if (elig[cur_thread] && (qcnt < QCNT_W'(QUANTUM))) begin
                    qcnt            <= qcnt + QCNT_W'(1);
                    valid_q         <= 1'b1;
                    cnt[cur_thread] <= sat_inc(cnt[cur_thread]);
                end else begin
                    rr_ptr <= cur_thread + 2'd1;
                    if (SWITCH_PENALTY == 0) begin
                        // No bubble: re-pick now; current thread only wins if alone.
                        if (pick_nx[2]) begin
                            cur_thread       <= pick_nx[1:0];
                            valid_q          <= 1'b1;
                            qcnt             <= QCNT_W'(1);
                            cnt[pick_nx[1:0]] <= sat_inc(cnt[pick_nx[1:0]]);
                        end else begin
                            state   <= S_IDLE;
                            valid_q <= 1'b0;
                        end
                    end else begin
                        state   <= S_SWITCH;
                        valid_q <= 1'b0;
                        pcnt    <= PCNT_W'(SWITCH_PENALTY - 1);
                    end
                end
            end else if ((state == S_SWITCH) && (pcnt != '0)) begin
                pcnt    <= pcnt - PCNT_W'(1);
                valid_q <= 1'b0;
            end else begin
                // IDLE, or the last switch bubble has drained.
                if (pick_rr[2]) begin
                    state             <= S_RUN;
                    cur_thread        <= pick_rr[1:0];
                    valid_q           <= 1'b1;
                    qcnt              <= QCNT_W'(1);
                    cnt[pick_rr[1:0]] <= sat_inc(cnt[pick_rr[1:0]]);
                end else begin
                    state   <= S_IDLE;
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.o_thread      = cur_thread;
    assign bus.o_Valid       = valid_q;
    assign bus.o_Demux_Flush = ~valid_q;
    assign bus.o_Issue_Count = {cnt[3], cnt[2], cnt[1], cnt[0]};

endmodule
